// File: rtl/mult_n_pkg.sv
// Shared types and width helpers for the N-operand sequential multiplier.
package mult_n_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int res_width(input int width, input int num_operands);
    return width * num_operands;
  endfunction

  // Smallest r with 2**r >= v; elaboration-time only.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_add_step.sv
// One shift-add bit step: conditionally adds the shifted accumulator into the partial sum.
module shift_add_step #(
  parameter int RES_W = 96,
  parameter int IDX_W = 5
) (
  input  logic [RES_W-1:0] partial,
  input  logic [RES_W-1:0] acc,
  input  logic [IDX_W-1:0] idx,
  input  logic             bit_set,
  output logic [RES_W-1:0] partial_next
);

  assign partial_next = partial + (bit_set ? (acc << idx) : '0);

endmodule

// File: rtl/seq_multiplier_n_operands.sv
// Sequential unsigned product of NUM_OPERANDS operands, one shift-add bit per clock,
// with Idle/Valid/Done/Acknowledge handshake.
//   state | meaning
//   IDLE  | waiting for iValid_Data; operands captured on request
//   MULT  | one multiplier bit per edge, operand by operand
//   DONE  | oResult valid, waiting for iAcknoledged
module seq_multiplier_n_operands
  import mult_n_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int NUM_OPERANDS = 3,
  parameter bit ZERO_SKIP    = 1'b1,
  localparam int RES_W       = res_width(WIDTH, NUM_OPERANDS)
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NUM_OPERANDS*WIDTH-1:0] iData,
  input  logic                          iValid_Data,
  input  logic                          iAcknoledged,
  output logic                          oIdle,
  output logic                          oDone,
  output logic [RES_W-1:0]              oResult
);

  localparam int BIT_W = clog2(WIDTH);
  localparam int OP_W  = clog2(NUM_OPERANDS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [OP_W-1:0]  OP_LAST  = OP_W'(NUM_OPERANDS - 1);

  state_t             state;
  logic [WIDTH-1:0]   op_q [NUM_OPERANDS];
  logic [RES_W-1:0]   acc;
  logic [RES_W-1:0]   partial;
  logic [RES_W-1:0]   partial_next;
  logic [BIT_W-1:0]   bit_cnt;
  logic [OP_W-1:0]    op_cnt;
  logic [WIDTH-1:0]   cur_op;
  logic               any_zero;

  always_comb begin
    any_zero = 1'b0;
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      if (iData[k*WIDTH +: WIDTH] == '0) any_zero = 1'b1;
    end
  end

  assign cur_op = op_q[op_cnt];

  shift_add_step #(
    .RES_W (RES_W),
    .IDX_W (BIT_W)
  ) u_step (
    .partial      (partial),
    .acc          (acc),
    .idx          (bit_cnt),
    .bit_set      (cur_op[bit_cnt]),
    .partial_next (partial_next)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      oIdle   <= 1'b1;
      oDone   <= 1'b0;
      oResult <= '0;
      acc     <= '0;
      partial <= '0;
      bit_cnt <= '0;
      op_cnt  <= '0;
      for (int k = 0; k < NUM_OPERANDS; k++) op_q[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iValid_Data) begin
            for (int k = 0; k < NUM_OPERANDS; k++) op_q[k] <= iData[k*WIDTH +: WIDTH];
            acc     <= RES_W'(iData[WIDTH-1:0]);
            partial <= '0;
            bit_cnt <= '0;
            op_cnt  <= OP_W'(1);
            oIdle   <= 1'b0;
            if (ZERO_SKIP && any_zero) begin
              oResult <= '0;
              oDone   <= 1'b1;
              state   <= DONE;
            end else begin
              state   <= MULT;
            end
          end
        end
        MULT: begin
          if (bit_cnt == BIT_LAST) begin
            // Operand finished: its product becomes the new multiplicand.
            acc     <= partial_next;
            partial <= '0;
            bit_cnt <= '0;
            if (op_cnt == OP_LAST) begin
              oResult <= partial_next;
              oDone   <= 1'b1;
              state   <= DONE;
            end else begin
              op_cnt  <= op_cnt + OP_W'(1);
            end
          end else begin
            partial <= partial_next;
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        DONE: begin
          if (iAcknoledged) begin
            oDone <= 1'b0;
            oIdle <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          oDone <= 1'b0;
          oIdle <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_n_operands.sv
// Directed-vector bench for seq_multiplier_n_operands: default, no-zero-skip and 8x4 instances.
module tb_seq_multiplier_n_operands;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Default instance (WIDTH=32, NUM_OPERANDS=3, ZERO_SKIP=1)
  logic [95:0] a_data = '0;
  logic        a_valid = 1'b0, a_ack = 1'b0;
  logic        a_idle, a_done;
  logic [95:0] a_result;

  // ZERO_SKIP=0 instance
  logic [95:0] z_data = '0;
  logic        z_valid = 1'b0, z_ack = 1'b0;
  logic        z_idle, z_done;
  logic [95:0] z_result;

  // WIDTH=8, NUM_OPERANDS=4 instance
  logic [31:0] w_data = '0;
  logic        w_valid = 1'b0, w_ack = 1'b0;
  logic        w_idle, w_done;
  logic [31:0] w_result;

  seq_multiplier_n_operands u_dut_a (
    .Clock(Clock), .Reset(Reset), .iData(a_data), .iValid_Data(a_valid),
    .iAcknoledged(a_ack), .oIdle(a_idle), .oDone(a_done), .oResult(a_result)
  );

  seq_multiplier_n_operands #(.ZERO_SKIP(1'b0)) u_dut_z (
    .Clock(Clock), .Reset(Reset), .iData(z_data), .iValid_Data(z_valid),
    .iAcknoledged(z_ack), .oIdle(z_idle), .oDone(z_done), .oResult(z_result)
  );

  seq_multiplier_n_operands #(.WIDTH(8), .NUM_OPERANDS(4)) u_dut_w (
    .Clock(Clock), .Reset(Reset), .iData(w_data), .iValid_Data(w_valid),
    .iAcknoledged(w_ack), .oIdle(w_idle), .oDone(w_done), .oResult(w_result)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // All request tasks start and end on a falling edge.
  task automatic req_a(input logic [95:0] data, output logic [95:0] res, output int lat);
    a_data = data; a_valid = 1'b1;
    @(posedge Clock); @(negedge Clock);
    a_valid = 1'b0;
    check("a_idle_busy", a_idle, 1'b0);
    lat = 0;
    while (!a_done && lat < 200) begin
      @(posedge Clock); lat++; @(negedge Clock);
    end
    res = a_result;
  endtask

  task automatic ack_a();
    a_ack = 1'b1;
    @(posedge Clock); @(negedge Clock);
    a_ack = 1'b0;
    check("a_idle_after_ack", a_idle, 1'b1);
    check("a_done_after_ack", a_done, 1'b0);
  endtask

  task automatic req_z(input logic [95:0] data, output logic [95:0] res, output int lat);
    z_data = data; z_valid = 1'b1;
    @(posedge Clock); @(negedge Clock);
    z_valid = 1'b0;
    lat = 0;
    while (!z_done && lat < 200) begin
      @(posedge Clock); lat++; @(negedge Clock);
    end
    res = z_result;
    z_ack = 1'b1;
    @(posedge Clock); @(negedge Clock);
    z_ack = 1'b0;
  endtask

  task automatic req_w(input logic [31:0] data, output logic [31:0] res, output int lat);
    w_data = data; w_valid = 1'b1;
    @(posedge Clock); @(negedge Clock);
    w_valid = 1'b0;
    lat = 0;
    while (!w_done && lat < 200) begin
      @(posedge Clock); lat++; @(negedge Clock);
    end
    res = w_result;
    w_ack = 1'b1;
    @(posedge Clock); @(negedge Clock);
    w_ack = 1'b0;
  endtask

  initial begin
    logic [95:0] res96;
    logic [31:0] res32;
    int          lat;
    int          idle_rises, done_seen;
    logic        prev_idle;
    int unsigned o0, o1, o2, o3;
    longint unsigned ref_prod;

    repeat (2) @(negedge Clock);
    check("rst_idle", a_idle, 1'b1);
    check("rst_done", a_done, 1'b0);
    check("rst_result", a_result, 96'd0);
    check("rst_w_idle", w_idle, 1'b1);
    Reset = 1'b0;
    @(negedge Clock);

    // 3*2*1, full latency
    req_a({32'd3, 32'd2, 32'd1}, res96, lat);
    check("small_latency", lat, 64);
    check("small_result", res96, 96'd6);
    ack_a();

    // Max operands, no truncation
    @(negedge Clock);
    req_a({3{32'hFFFF_FFFF}}, res96, lat);
    check("max_latency", lat, 64);
    check("max_result", res96, 96'hFFFF_FFFD_0000_0002_FFFF_FFFF);
    ack_a();

    // Zero operand short-circuits
    @(negedge Clock);
    req_a({32'd5, 32'd0, 32'd7}, res96, lat);
    check("zskip_latency", lat, 0);
    check("zskip_result", res96, 96'd0);
    ack_a();

    // Mid-computation iData change and Valid pulse are ignored
    @(negedge Clock);
    a_data = {32'd7, 32'd6, 32'd5}; a_valid = 1'b1;
    @(posedge Clock); @(negedge Clock);
    a_valid = 1'b0;
    lat = 0;
    repeat (10) begin @(posedge Clock); lat++; end
    @(negedge Clock);
    a_data = {32'd9, 32'd9, 32'd9}; a_valid = 1'b1;
    @(posedge Clock); lat++; @(negedge Clock);
    a_valid = 1'b0;
    while (!a_done && lat < 200) begin
      @(posedge Clock); lat++; @(negedge Clock);
    end
    check("ignore_latency", lat, 64);
    check("ignore_result", a_result, 96'd210);
    repeat (5) @(posedge Clock);
    @(negedge Clock);
    check("hold_done", a_done, 1'b1);
    check("hold_result", a_result, 96'd210);

    // Ack held for 50 cycles: a single return to IDLE, no re-trigger
    a_ack = 1'b1;
    idle_rises = 0; done_seen = 0; prev_idle = a_idle;
    repeat (50) begin
      @(posedge Clock); @(negedge Clock);
      if (a_idle && !prev_idle) idle_rises++;
      if (a_done) done_seen++;
      prev_idle = a_idle;
    end
    a_ack = 1'b0;
    check("ack_idle_rises", idle_rises, 1);
    check("ack_done_cycles", done_seen, 0);
    check("idle_keeps_result", a_result, 96'd210);

    // Async reset during MULT aborts the operation
    @(negedge Clock);
    a_data = {32'd3, 32'd2, 32'd1}; a_valid = 1'b1;
    @(posedge Clock); @(negedge Clock);
    a_valid = 1'b0;
    repeat (30) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("abort_idle", a_idle, 1'b1);
    check("abort_done", a_done, 1'b0);
    check("abort_result", a_result, 96'd0);
    @(negedge Clock);
    Reset = 1'b0;
    done_seen = 0;
    repeat (80) begin
      @(posedge Clock); @(negedge Clock);
      if (a_done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    req_a({32'd4, 32'd5, 32'd6}, res96, lat);
    check("post_abort_latency", lat, 64);
    check("post_abort_result", res96, 96'd120);
    ack_a();

    // ZERO_SKIP=0: zero operand takes full latency
    req_z({32'd5, 32'd0, 32'd7}, res96, lat);
    check("nozskip_latency", lat, 64);
    check("nozskip_result", res96, 96'd0);
    req_z({32'd11, 32'd13, 32'd17}, res96, lat);
    check("nozskip_nonzero", res96, 96'd2431);

    // 8-bit x 4 operands
    req_w({8'd10, 8'd3, 8'd16, 8'd255}, res32, lat);
    check("w8_latency", lat, 24);
    check("w8_result", res32, 32'd122400);

    // Back-to-back incrementing requests against a bench-side product
    for (int i = 0; i < 20; i++) begin
      o0 = i + 1; o1 = i + 3; o2 = 2 * i + 5; o3 = 250 - 7 * i;
      ref_prod = longint'(o0) * o1 * o2 * o3;
      req_w({o3[7:0], o2[7:0], o1[7:0], o0[7:0]}, res32, lat);
      check($sformatf("b2b_result_%0d", i), res32, ref_prod[31:0]);
      check($sformatf("b2b_latency_%0d", i), lat, 24);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
